// File: rtl/id_issue_ctrl_pkg.sv
// Shared definitions for the decode-to-execute issue controller.
// Holds the register-file geometry, the instruction width, the x0 index and
// a one-hot decode helper used to build scoreboard masks.
package id_issue_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NR_REGS    = 32;
  localparam int INST_W     = 32;

  localparam logic [REG_ADDR_W-1:0] X0_ADDR = '0;

  function automatic logic [NR_REGS-1:0] onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NR_REGS-1:0] m;
    m       = '0;
    m[addr] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Register scoreboard: one pending bit per architectural register.
//
// Ports:
//   clk, rst               clock, synchronous active-low reset
//   set_ena/set_addr       mark a destination pending (issue)
//   clr_ena/clr_addr       retire a destination (writeback)
//   fl_ena/fl_addr         drop the destination of a flushed instruction
//   rs1/rs2/rd_addr        lookup indices
//   rs1/rs2/rd_busy        lookup results, writeback-bypassed
//   pending                registered bitmap, bit 0 always 0
module id_scoreboard
  import id_issue_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_ena,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_ena,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic                  fl_ena,
  input  logic [REG_ADDR_W-1:0] fl_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rd_busy,
  output logic [NR_REGS-1:0]    pending
);

  logic [NR_REGS-1:0] pend_q;
  logic [NR_REGS-1:0] clr_mask;
  logic [NR_REGS-1:0] fl_mask;
  logic [NR_REGS-1:0] set_mask;
  logic [NR_REGS-1:0] pend_eff;
  logic [NR_REGS-1:0] pend_nxt;

  assign clr_mask = clr_ena ? onehot(clr_addr) : '0;
  assign fl_mask  = fl_ena  ? onehot(fl_addr)  : '0;
  assign set_mask = set_ena ? onehot(set_addr) : '0;

  // Writeback retirement is bypassed into the lookups so a dependent
  // instruction can issue in the same cycle its producer writes back.
  assign pend_eff = pend_q & ~clr_mask;

  assign rs1_busy = pend_eff[rs1_addr] & (rs1_addr != X0_ADDR);
  assign rs2_busy = pend_eff[rs2_addr] & (rs2_addr != X0_ADDR);
  assign rd_busy  = pend_eff[rd_addr]  & (rd_addr  != X0_ADDR);

  // A new issue to the same register as a retiring write keeps the bit set.
  always_comb begin
    pend_nxt          = (pend_eff & ~fl_mask) | set_mask;
    pend_nxt[X0_ADDR] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) pend_q <= '0;
    else      pend_q <= pend_nxt;
  end

  assign pending = pend_q;

endmodule

// File: rtl/id_issue_ctrl.sv
// Issue controller between decode and execute.
// Stalls decode on RAW/WAW hazards against in-flight destinations, owns the
// single ID->EX pipeline register (valid/ready on both sides), supports
// flushing the staged instruction and counts stall cycles with saturation.
//
// Ports:
//   clk, rst                          clock, synchronous active-low reset
//   id_valid/id_ready, id_inst        decode handshake and instruction
//   rs1/rs2_r_ena, rs1/rs2_r_addr     source reads of the decoding instruction
//   rd_w_ena, rd_w_addr               destination of the decoding instruction
//   ex_valid/ex_ready, ex_inst        execute handshake and staged instruction
//   ex_rd_w_ena, ex_rd_w_addr         staged destination
//   wb_valid, wb_rd_addr              writeback retirement
//   flush                             kill the staged instruction
//   pending                           scoreboard bitmap
//   stall_cnt                         saturating stall-cycle counter
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [INST_W-1:0]     id_inst,
  input  logic                  rs1_r_ena,
  input  logic                  rs2_r_ena,
  input  logic [REG_ADDR_W-1:0] rs1_r_addr,
  input  logic [REG_ADDR_W-1:0] rs2_r_addr,
  input  logic                  rd_w_ena,
  input  logic [REG_ADDR_W-1:0] rd_w_addr,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [INST_W-1:0]     ex_inst,
  output logic                  ex_rd_w_ena,
  output logic [REG_ADDR_W-1:0] ex_rd_w_addr,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  flush,
  output logic [NR_REGS-1:0]    pending,
  output logic [CNT_W-1:0]      stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic                  vld_p1;
  logic [INST_W-1:0]     inst_p1;
  logic                  rd_w_ena_p1;
  logic [REG_ADDR_W-1:0] rd_w_addr_p1;
  logic [CNT_W-1:0]      stall_cnt_q;

  logic rs1_busy;
  logic rs2_busy;
  logic rd_busy;
  logic hazard;
  logic accept;
  logic set_ena;
  logic fl_ena;

  assign hazard = (rs1_r_ena & rs1_busy) |
                  (rs2_r_ena & rs2_busy) |
                  (rd_w_ena  & rd_busy);

  assign accept   = rst & ~flush & id_valid & ~hazard & (~vld_p1 | ex_ready);
  assign id_ready = accept;

  assign set_ena = accept & rd_w_ena & (rd_w_addr != X0_ADDR);
  // The killed instruction will never write back, so its claim is dropped.
  assign fl_ena  = flush & vld_p1 & rd_w_ena_p1 & (rd_w_addr_p1 != X0_ADDR);

  id_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_ena  (set_ena),
    .set_addr (rd_w_addr),
    .clr_ena  (wb_valid),
    .clr_addr (wb_rd_addr),
    .fl_ena   (fl_ena),
    .fl_addr  (rd_w_addr_p1),
    .rs1_addr (rs1_r_addr),
    .rs2_addr (rs2_r_addr),
    .rd_addr  (rd_w_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy),
    .pending  (pending)
  );

  // ---- ID -> EX stage boundary ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1       <= 1'b0;
      inst_p1      <= '0;
      rd_w_ena_p1  <= 1'b0;
      rd_w_addr_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1       <= 1'b1;
      inst_p1      <= id_inst;
      rd_w_ena_p1  <= rd_w_ena;
      rd_w_addr_p1 <= rd_w_addr;
    end else if (ex_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                      stall_cnt_q <= '0;
    else if (id_valid & ~accept)   stall_cnt_q <= sat_inc(stall_cnt_q);
  end

  assign ex_valid     = vld_p1;
  assign ex_inst      = inst_p1;
  assign ex_rd_w_ena  = rd_w_ena_p1;
  assign ex_rd_w_addr = rd_w_addr_p1;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
module tb_id_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic        rs1_r_ena, rs2_r_ena;
  logic [4:0]  rs1_r_addr, rs2_r_addr;
  logic        rd_w_ena;
  logic [4:0]  rd_w_addr;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_inst;
  logic        ex_rd_w_ena;
  logic [4:0]  ex_rd_w_addr;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic        flush;
  logic [31:0] pending;
  logic [31:0] stall_cnt;

  logic        s_id_ready, s_ex_valid, s_ex_rd_w_ena;
  logic [31:0] s_ex_inst, s_pending;
  logic [4:0]  s_ex_rd_w_addr;
  logic [1:0]  s_stall_cnt;

  always #5 clk = ~clk;

  id_issue_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst),
    .rs1_r_ena(rs1_r_ena), .rs2_r_ena(rs2_r_ena), .rs1_r_addr(rs1_r_addr), .rs2_r_addr(rs2_r_addr),
    .rd_w_ena(rd_w_ena), .rd_w_addr(rd_w_addr), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_inst(ex_inst), .ex_rd_w_ena(ex_rd_w_ena), .ex_rd_w_addr(ex_rd_w_addr),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .flush(flush), .pending(pending),
    .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance to exercise saturation; shares all inputs.
  id_issue_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(s_id_ready), .id_inst(id_inst),
    .rs1_r_ena(rs1_r_ena), .rs2_r_ena(rs2_r_ena), .rs1_r_addr(rs1_r_addr), .rs2_r_addr(rs2_r_addr),
    .rd_w_ena(rd_w_ena), .rd_w_addr(rd_w_addr), .ex_valid(s_ex_valid), .ex_ready(ex_ready),
    .ex_inst(s_ex_inst), .ex_rd_w_ena(s_ex_rd_w_ena), .ex_rd_w_addr(s_ex_rd_w_addr),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .flush(flush), .pending(s_pending),
    .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    logic        rst, id_valid;
    logic [31:0] inst;
    logic        r1e; logic [4:0] r1;
    logic        r2e; logic [4:0] r2;
    logic        rde; logic [4:0] rd;
    logic        ex_ready, wbv; logic [4:0] wba;
    logic        flush;
    logic        e_ready, e_valid;
    logic [31:0] e_inst, e_pend, e_stall;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;

  function automatic vec_t mk(
    input logic r, input logic iv, input logic [31:0] inst,
    input logic r1e, input logic [4:0] r1, input logic r2e, input logic [4:0] r2,
    input logic rde, input logic [4:0] rd, input logic exr, input logic wbv,
    input logic [4:0] wba, input logic fl, input logic er, input logic ev,
    input logic [31:0] ei, input logic [31:0] ep, input logic [31:0] es);
    vec_t v;
    v.rst = r; v.id_valid = iv; v.inst = inst;
    v.r1e = r1e; v.r1 = r1; v.r2e = r2e; v.r2 = r2; v.rde = rde; v.rd = rd;
    v.ex_ready = exr; v.wbv = wbv; v.wba = wba; v.flush = fl;
    v.e_ready = er; v.e_valid = ev; v.e_inst = ei; v.e_pend = ep; v.e_stall = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    rst = v.rst; id_valid = v.id_valid; id_inst = v.inst;
    rs1_r_ena = v.r1e; rs1_r_addr = v.r1; rs2_r_ena = v.r2e; rs2_r_addr = v.r2;
    rd_w_ena = v.rde; rd_w_addr = v.rd; ex_ready = v.ex_ready;
    wb_valid = v.wbv; wb_rd_addr = v.wba; flush = v.flush;
    #1;
    chk({tag, ".id_ready"}, {31'b0, id_ready}, {31'b0, v.e_ready});
    @(posedge clk);
    #1;
    chk({tag, ".ex_valid"}, {31'b0, ex_valid}, {31'b0, v.e_valid});
    chk({tag, ".ex_inst"}, ex_inst, v.e_inst);
    chk({tag, ".pending"}, pending, v.e_pend);
    chk({tag, ".stall_cnt"}, stall_cnt, v.e_stall);
  endtask

  vec_t tbl[13];

  initial begin
    rst = 1'b0; id_valid = 1'b0; id_inst = '0; rs1_r_ena = 1'b0; rs1_r_addr = '0;
    rs2_r_ena = 1'b0; rs2_r_addr = '0; rd_w_ena = 1'b0; rd_w_addr = '0;
    ex_ready = 1'b0; wb_valid = 1'b0; wb_rd_addr = '0; flush = 1'b0;

    //            rst iv inst          r1e r1 r2e r2 rde rd exr wbv wba fl | rdy vld inst         pend         stall
    tbl[0]  = mk(0, 1, 32'h00100093, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0,  0, 0, 32'h0,        32'h0,        0);
    tbl[1]  = mk(0, 1, 32'h00100093, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0,  0, 0, 32'h0,        32'h0,        0);
    // back-to-back issue of x1, x2
    tbl[2]  = mk(1, 1, 32'h00100093, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0,  1, 1, 32'h00100093, 32'h2,        0);
    tbl[3]  = mk(1, 1, 32'h00200113, 1, 0, 0, 0, 1, 2, 1, 0, 0, 0,  1, 1, 32'h00200113, 32'h6,        0);
    tbl[4]  = mk(1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1, 1, 1, 0,  0, 0, 32'h00200113, 32'h4,        0);
    tbl[5]  = mk(1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1, 1, 2, 0,  0, 0, 32'h00200113, 32'h0,        0);
    // RAW on x5, resolved by same-cycle writeback; set wins over clear
    tbl[6]  = mk(1, 1, 32'h00500293, 1, 0, 0, 0, 1, 5, 1, 0, 0, 0,  1, 1, 32'h00500293, 32'h20,       0);
    tbl[7]  = mk(1, 1, 32'h00128293, 1, 5, 0, 0, 1, 5, 1, 0, 0, 0,  0, 0, 32'h00500293, 32'h20,       1);
    tbl[8]  = mk(1, 1, 32'h00128293, 1, 5, 0, 0, 1, 5, 1, 0, 0, 0,  0, 0, 32'h00500293, 32'h20,       2);
    tbl[9]  = mk(1, 1, 32'h00128293, 1, 5, 0, 0, 1, 5, 1, 1, 5, 0,  1, 1, 32'h00128293, 32'h20,       2);
    tbl[10] = mk(1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1, 1, 5, 0,  0, 0, 32'h00128293, 32'h0,        2);
    // x0 destination and source never hazard or go pending
    tbl[11] = mk(1, 1, 32'h00000013, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0,  1, 1, 32'h00000013, 32'h0,        2);
    tbl[12] = mk(1, 1, 32'h00100013, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0,  1, 1, 32'h00100013, 32'h0,        2);

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
      if (i == 1) begin
        chk("reset.ex_rd_w_ena", {31'b0, ex_rd_w_ena}, 32'h0);
        chk("reset.ex_rd_w_addr", {27'b0, ex_rd_w_addr}, 32'h0);
      end
    end

    // Backpressure: staged instruction held for 4 cycles, then released.
    for (int k = 0; k < 4; k++)
      apply(mk(1, 1, 32'h00700393, 1, 0, 0, 0, 1, 7, 0, 0, 0, 0,
               0, 1, 32'h00100013, 32'h0, 32'(3 + k)), $sformatf("bp%0d", k));
    apply(mk(1, 1, 32'h00700393, 1, 0, 0, 0, 1, 7, 1, 0, 0, 0,
             1, 1, 32'h00700393, 32'h80, 6), "bp_release");
    chk("bp_release.ex_rd_w_addr", {27'b0, ex_rd_w_addr}, 32'd7);

    // Flush kills staged x7 and blocks the waiting instruction for one cycle.
    apply(mk(1, 1, 32'h00800413, 1, 0, 0, 0, 1, 8, 1, 0, 0, 1,
             0, 0, 32'h00700393, 32'h0, 7), "flush");
    apply(mk(1, 1, 32'h00800413, 1, 0, 0, 0, 1, 8, 1, 0, 0, 0,
             1, 1, 32'h00800413, 32'h100, 7), "post_flush");

    // WAW on x8, then RAW through rs2.
    apply(mk(1, 1, 32'h00900413, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0,
             0, 0, 32'h00800413, 32'h100, 8), "waw");
    apply(mk(1, 1, 32'h008004b3, 1, 0, 1, 8, 1, 9, 1, 0, 0, 0,
             0, 0, 32'h00800413, 32'h100, 9), "raw_rs2");
    chk("sat.stall_cnt", {30'b0, s_stall_cnt}, 32'h3);

    // Reset mid-operation with a pending bit and an acceptable request.
    apply(mk(0, 1, 32'h00a00513, 0, 0, 0, 0, 1, 10, 1, 1, 8, 0,
             0, 0, 32'h0, 32'h0, 0), "mid_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_issue_ctrl.md
# id_issue_ctrl

Issue controller between the decode stage and the execute stage. It holds a register scoreboard of pending destination writes and stalls decode on RAW/WAW hazards against in-flight instructions. It owns the single ID→EX pipeline register with a valid/ready handshake and retires scoreboard entries on writeback. It also provides flush and a saturating stall-cycle performance counter.

## Interface
Parameters:
- `CNT_W`, 32, width of the stall counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low (`rst == 0` resets).
- `id_valid`  in  1  decode presents an instruction.
- `id_ready`  out  1  instruction accepted at this edge.
- `id_inst`  in  32  decoded instruction word.
- `rs1_r_ena`, `rs2_r_ena`  in  1  source-read enables from decode.
- `rs1_r_addr`, `rs2_r_addr`  in  5  source register indices.
- `rd_w_ena`  in  1  destination-write enable.
- `rd_w_addr`  in  5  destination register index.
- `ex_valid`  out  1  pipeline register holds an instruction.
- `ex_ready`  in  1  execute consumes the staged instruction at this edge.
- `ex_inst`  out  32  staged instruction.
- `ex_rd_w_ena`  out  1  staged write enable.
- `ex_rd_w_addr`  out  5  staged destination.
- `wb_valid`  in  1  writeback retires a register write.
- `wb_rd_addr`  in  5  retiring destination.
- `flush`  in  1  kill the staged instruction.
- `pending`  out  32  scoreboard bitmap; bit 0 is always 0.
- `stall_cnt`  out  CNT_W  saturating count of stall cycles.

## Operation
- Effective pending: `pend_eff = pending & ~wb_mask`, where `wb_mask` is the one-hot of `wb_rd_addr` when `wb_valid` is 1. Writeback clears are visible to the hazard check in the same cycle.
- Hazard is asserted when any of the following holds:
  - `rs1_r_ena & pend_eff[rs1_r_addr]`
  - `rs2_r_ena & pend_eff[rs2_r_addr]`
  - `rd_w_ena & pend_eff[rd_w_addr]` (WAW)
- Register x0 never creates a hazard and is never set pending.
- Acceptance: `id_ready = rst & ~flush & id_valid & ~hazard & (~ex_valid | ex_ready)`.
- On accept, the next edge does the following:
  - load `ex_inst`, `ex_rd_w_ena` and `ex_rd_w_addr`; set `ex_valid = 1`;
  - set `pending[rd_w_addr]` if `rd_w_ena` is 1 and `rd_w_addr != 0`.
- With no accept and `ex_ready = 1`: `ex_valid` goes to 0 and the staged fields hold their old values.
- With no accept and `ex_ready = 0`: everything holds.
- Writeback clears `pending[wb_rd_addr]`. If a set and a clear hit the same bit in one cycle, the set wins.
- Flush takes priority over `ex_ready`:
  - the staged instruction is killed and `ex_valid` goes to 0;
  - if the killed instruction had `ex_rd_w_ena` with a nonzero address, its pending bit is cleared;
  - no accept happens in the flush cycle;
  - writeback is still processed in the flush cycle.
- Instructions already consumed by execute complete normally.
- `stall_cnt` increments when `id_valid & ~id_ready & rst` is true, and saturates at all-ones.

## Timing
- Reset values: `ex_valid` 0, `ex_inst` 0, `ex_rd_w_ena` 0, `ex_rd_w_addr` 0, `pending` 0, `stall_cnt` 0. `id_ready` is 0 combinationally while `rst` is 0.
- Latency: an instruction accepted at edge N is visible on `ex_*` after edge N; a throughput of 1 per cycle is possible.
- Paths from `wb_valid`/`wb_rd_addr` to `id_ready` and from `ex_ready` to `id_ready` are combinational.
- `ex_*` outputs are registers, held stable while `ex_valid & ~ex_ready`.
- Reset asserted mid-operation wins over every other input at that edge.

## Structure
- Shared package holds `REG_ADDR_W = 5`, `NR_REGS = 32`, `INST_W = 32` and the x0 index constant.
- One sub-module, `id_scoreboard`:
  - inputs: set enable/address, clear enable/address, flush-clear enable/address;
  - outputs: the pending bitmap plus three combinational lookup ports (rs1, rs2, rd) with writeback bypass.
- The top level holds the pipeline register, the handshake and the counter.

## Test plan
- Reset: hold `rst = 0` for 2 cycles with `id_valid = 1` → `id_ready = 0`, `ex_valid = 0`, `pending = 0`, `stall_cnt = 0`.
- Back-to-back: issue addi x1 then addi x2 with `ex_ready = 1` → accepted on consecutive cycles and `pending = 0x6`.
- RAW: issue rd = x5, then an instruction with rs1 = x5 → `id_ready = 0` and `stall_cnt` counts +1 per cycle. Apply `wb_valid = 1`, `wb_rd_addr = 5` → accepted in that same cycle, and `pending[5]` ends at 1 (set wins over clear).
- x0: rd = 0 then rs1 = 0 → `pending` stays 0 and there is no stall.
- Backpressure: hold `ex_ready = 0` with `ex_valid = 1` → `id_ready = 0` and `ex_inst` stays stable for 4 cycles. Release → the next instruction is accepted.
- Flush: staged rd = x7, `flush = 1`, `ex_ready = 1` → `ex_valid = 0` next cycle, `pending[7] = 0`, and `id_ready = 0` during the flush cycle.
